lsu_mem_ctrl: RTL and testbench

//  Load/store unit front end that sits directly upstream of the DPI-backed memory block.
//  - Accepts one load/store request at a time from EXU over a valid/ready handshake.
//  - Drives the combinational memory port for exactly one cycle per access.
//  - Returns aligned, extended load data (or a store ack) over a second valid/ready handshake.
//  - Owns byte-strobe generation, lane shifting, sign/zero extension and misalignment detection.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 39 +++
 rtl/lsu_mem_ctrl.sv | 109 ++++++++++
 tb/tb_lsu_mem_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared op encodings, access sizes, FSM state codes and decode helpers for the LSU front end.
package lsu_pkg;

  localparam int LSU_W = 32;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // funct3 values x11 and 11x have no defined width
  function automatic logic op_undef(input logic [2:0] funct3);
    return (funct3[1:0] == 2'b11) || (funct3[2:1] == 2'b11);
  endfunction

  function automatic logic [1:0] op_size(input logic [2:0] funct3);
    return op_undef(funct3) ? SZ_W : funct3[1:0];
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte strobes, store-data lane shift and load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic [1:0]       off,
  input  logic [LSU_W-1:0] wdata,
  input  logic [LSU_W-1:0] rdata,
  output logic [3:0]       wstrb,
  output logic [LSU_W-1:0] wdata_lane,
  output logic [LSU_W-1:0] rdata_ext
);

  logic [1:0]       size;
  logic             sext;
  logic [LSU_W-1:0] shifted;

  always_comb begin
    size       = op_size(funct3);
    sext       = !funct3[2];
    shifted    = rdata >> {off, 3'b000};
    wdata_lane = wdata << {off, 3'b000};
    case (size)
      SZ_B: begin
        wstrb     = 4'b0001 << off;
        rdata_ext = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        wstrb     = 4'b0011 << off;
        rdata_ext = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        wstrb     = 4'b1111;
        rdata_ext = shifted;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// LSU front end: one request at a time, one-cycle memory strobe, registered response.
// Accept->access->response takes 2 cycles; held responses stall new requests via req_ready.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        state;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              accept;
  logic              req_bad;
  logic [3:0]        lane_strb;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] load_data;

  lsu_align u_align (
    .funct3     (op_q[2:0]),
    .off        (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .wstrb      (lane_strb),
    .wdata_lane (lane_wdata),
    .rdata_ext  (load_data)
  );

  always_comb begin
    req_ready  = reset && ((state == ST_IDLE) || ((state == ST_RESP) && resp_ready));
    resp_valid = reset && (state == ST_RESP);
    accept     = req_valid && req_ready;
    req_bad    = op_undef(req_op[2:0]) ||
                 (CHECK_ALIGN && misaligned(op_size(req_op[2:0]), req_addr[1:0]));
  end

  // Gating on reset keeps the DPI memory from seeing an access during a reset cycle
  always_comb begin
    mem_en    = reset && (state == ST_ACCESS);
    mem_wr    = mem_en ? !op_q[3] : 1'b1;
    mem_wstrb = mem_en ? lane_strb : 4'b0000;
    mem_addr  = mem_en ? {addr_q[ADDR_W-1:2], 2'b00} : mem_addr_q;
    mem_wdata = mem_en ? lane_wdata : mem_wdata_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        ST_ACCESS: begin
          state       <= ST_RESP;
          resp_rdata  <= op_q[3] ? '0 : load_data;
          resp_err    <= 1'b0;
          mem_addr_q  <= {addr_q[ADDR_W-1:2], 2'b00};
          mem_wdata_q <= lane_wdata;
        end
        ST_RESP: begin
          if (resp_ready && !req_valid) state <= ST_IDLE;
        end
        default: ;
      endcase
      // A bad request skips the access and answers with an error next cycle
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (req_bad) begin
          state      <= ST_RESP;
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end else begin
          state <= ST_ACCESS;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases plus random traffic against a byte-addressed memory model.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .CHECK_ALIGN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int en_cnt = 0;
  int en_cycs[$];
  logic        cap_wr;
  logic [3:0]  cap_strb;
  logic [31:0] cap_addr, cap_wdata;
  logic [7:0]  tb_mem [0:63];
  logic [7:0]  ref_mem [0:63];
  logic [31:0] last_rdata;
  logic        last_err;

  assign mem_rdata = {tb_mem[{mem_addr[5:2], 2'd3}], tb_mem[{mem_addr[5:2], 2'd2}],
                      tb_mem[{mem_addr[5:2], 2'd1}], tb_mem[{mem_addr[5:2], 2'd0}]};

  always @(posedge clock) cyc <= cyc + 1;

  // Memory side: record each strobe and apply writes with byte enables
  always @(negedge clock) begin
    if (mem_en) begin
      en_cnt <= en_cnt + 1;
      en_cycs.push_back(cyc);
      cap_wr    <= mem_wr;
      cap_strb  <= mem_wstrb;
      cap_addr  <= mem_addr;
      cap_wdata <= mem_wdata;
      if (!mem_wr)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) tb_mem[{mem_addr[5:2], 2'(b)}] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Reference: byte-addressed memory, size from funct3, aligned accesses only
  function automatic void model(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic err,
                                output logic [31:0] rd);
    int f3, nb, a;
    logic [31:0] v;
    f3 = int'(op[2:0]);
    a  = int'(addr[5:0]);
    rd = 32'h0;
    err = 1'b0;
    if (f3 == 3 || f3 >= 6) begin err = 1'b1; return; end
    nb = 1 << (f3 % 4);
    if ((a % nb) != 0) begin err = 1'b1; return; end
    if (op[3]) begin
      for (int i = 0; i < nb; i++) ref_mem[a + i] = 8'(wdata >> (8 * i));
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v + (32'(ref_mem[a + i]) << (8 * i));
      if (f3 < 4 && nb < 4 && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
      rd = v;
    end
  endfunction

  task automatic run_txn(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold);
    logic m_err, h_err;
    logic [31:0] m_rd, h_rd;
    int en0, k;
    model(op, addr, wdata, m_err, m_rd);
    en0 = en_cnt;
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1; resp_ready = 1'b0;
    #1;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    k = 1;
    while (!resp_valid && k < 8) begin tick(); k++; end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_latency", k, m_err ? 32'd1 : 32'd2);
    chk("resp_err", 32'(resp_err), 32'(m_err));
    chk("resp_rdata", resp_rdata, m_rd);
    chk("mem_en_count", en_cnt - en0, m_err ? 32'd0 : 32'd1);
    h_rd = resp_rdata; h_err = resp_err;
    last_rdata = resp_rdata; last_err = resp_err;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, h_rd);
      chk("hold_err", 32'(resp_err), 32'(h_err));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    #1;
    chk("req_ready_resp", 32'(req_ready), 32'd1);
    tick();
    resp_ready = 1'b0;
    chk("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  d_op  [5] = '{OP_LB, OP_LB, OP_LBU, OP_LH, OP_LHU};
    logic [1:0]  d_off [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    logic [31:0] d_exp [5] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFF8000, 32'h00008000};
    logic e1, e2;
    logic [31:0] r1, r2, hrd, word;
    int en0, n;

    for (int i = 0; i < 64; i++) begin
      tb_mem[i] = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd1);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    reset = 1'b1;
    tick();

    run_txn(OP_SW, 32'h80000004, 32'hDEADBEEF, 0);
    chk("sw_mem_wr", 32'(cap_wr), 32'd0);
    chk("sw_wstrb", 32'(cap_strb), 32'hF);
    chk("sw_mem_addr", cap_addr, 32'h80000004);
    chk("sw_mem_wdata", cap_wdata, 32'hDEADBEEF);
    chk("sw_rdata", last_rdata, 32'd0);

    run_txn(OP_SB, 32'h80000003, 32'h000000A5, 1);
    chk("sb_wstrb", 32'(cap_strb), 32'h8);
    chk("sb_mem_wdata", cap_wdata, 32'hA5000000);
    chk("idle_mem_wr", 32'(mem_wr), 32'd1);
    chk("idle_wstrb", 32'(mem_wstrb), 32'd0);
    chk("idle_addr_held", mem_addr, 32'h80000000);
    chk("idle_wdata_held", mem_wdata, 32'hA5000000);

    run_txn(OP_SH, 32'h80000006, 32'h0000BEEF, 0);
    chk("sh_wstrb", 32'(cap_strb), 32'hC);
    chk("sh_mem_wdata", cap_wdata, 32'hBEEF0000);

    {tb_mem[19], tb_mem[18], tb_mem[17], tb_mem[16]} = 32'h8000FF7F;
    {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]} = 32'h8000FF7F;
    for (int i = 0; i < 5; i++) begin
      run_txn(d_op[i], 32'h80000010 + 32'(d_off[i]), 32'h0, 0);
      chk("load_ext", last_rdata, d_exp[i]);
      chk("load_mem_wr", 32'(cap_wr), 32'd1);
    end

    run_txn(OP_LW, 32'h80000002, 32'h0, 0);
    chk("lw_misaligned_err", 32'(last_err), 32'd1);

    // Back-to-back SW then LW with resp_ready high and req_valid held
    model(OP_SW, 32'h80000020, 32'hDEADBEEF, e1, r1);
    model(OP_LW, 32'h80000020, 32'h0, e2, r2);
    en0 = en_cnt;
    req_op = OP_SW; req_addr = 32'h80000020; req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1; resp_ready = 1'b1;
    tick();
    chk("b2b_en1", 32'(mem_en), 32'd1);
    chk("b2b_access_ready", 32'(req_ready), 32'd0);
    req_op = OP_LW; req_wdata = 32'h0;
    tick();
    chk("b2b_resp1_valid", 32'(resp_valid), 32'd1);
    chk("b2b_resp1_err", 32'(resp_err), 32'(e1));
    chk("b2b_resp1_rdata", resp_rdata, r1);
    chk("b2b_resp1_ready", 32'(req_ready), 32'd1);
    tick();
    chk("b2b_en2", 32'(mem_en), 32'd1);
    chk("b2b_gap", en_cycs[en_cycs.size()-1] - en_cycs[en_cycs.size()-2], 32'd2);
    req_valid = 1'b0; resp_ready = 1'b0;
    tick();
    chk("b2b_resp2_valid", 32'(resp_valid), 32'd1);
    chk("b2b_resp2_rdata", resp_rdata, r2);
    chk("b2b_resp2_const", resp_rdata, 32'hDEADBEEF);
    hrd = resp_rdata;
    for (int i = 0; i < 3; i++) begin
      chk("b2b_stall_valid", 32'(resp_valid), 32'd1);
      chk("b2b_stall_rdata", resp_rdata, hrd);
      chk("b2b_stall_ready", 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("b2b_release_ready", 32'(req_ready), 32'd1);
    tick();
    resp_ready = 1'b0;
    chk("b2b_drop", 32'(resp_valid), 32'd0);
    chk("b2b_en_count", en_cnt - en0, 32'd2);

    // Reset asserted during the access cycle of a store
    en0 = en_cnt;
    req_op = OP_SW; req_addr = 32'h80000030; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("rst_access_mem_en", 32'(mem_en), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("rst_after_valid", 32'(resp_valid), 32'd0);
    chk("rst_after_ready", 32'(req_ready), 32'd1);
    chk("rst_no_access", en_cnt - en0, 32'd0);

    for (int t = 0; t < 150; t++) begin
      run_txn(4'($urandom_range(0, 15)), 32'h80000000 + 32'($urandom_range(0, 63)),
              $urandom, int'($urandom_range(0, 2)));
    end

    for (int w = 0; w < 16; w++) begin
      word = {tb_mem[4*w+3], tb_mem[4*w+2], tb_mem[4*w+1], tb_mem[4*w]};
      chk("mem_final", word, {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
    end
    n = n_checks;
    $display("Result: errors=%0d of %0d checks", n_errors, n);
    $finish;
  end

endmodule
